// File: rtl/rc5_sched_pkg.sv
// rc5_sched_pkg: shared types and defaults for the RC5 job scheduler.
// FSM state encoding, op encodings and default parameter values.
package rc5_sched_pkg;

  localparam int W_DEF       = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  localparam logic OP_CIPHER   = 1'b0;
  localparam logic OP_DECIPHER = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, purely combinational.
// ptr names the requester that wins when both are valid.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant; contention resolved by ptr.
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rc5_job_scheduler.sv
// rc5_job_scheduler: accepts RC5 jobs from two requesters, one in flight.
// Define RC5_SCHED_TIMEOUT_EN to add a RUN-state watchdog (rsp_err).
module rc5_job_scheduler
  import rc5_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_dec,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [W-1:0]     rsp_a,
  output logic [W-1:0]     rsp_b,
  output logic             o_start_cipher,
  output logic             o_start_decipher,
  output logic [W-1:0]     o_a,
  output logic [W-1:0]     o_b,
  input  logic             i_done_cipher,
  input  logic             i_done_decipher,
  input  logic [W-1:0]     i_a_cipher,
  input  logic [W-1:0]     i_b_cipher,
  input  logic [W-1:0]     i_a_decipher,
  input  logic [W-1:0]     i_b_decipher,
  output logic             o_key_busy
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rc5_job_scheduler: TIMEOUT must be >= 1");
  end

  sched_state_e r_state;
  sched_state_e w_state_nxt;

  logic             r_ptr;
  logic             r_op;
  logic             r_id;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [TAG_W-1:0] r_tag;
  logic [W-1:0]     r_rsp_a;
  logic [W-1:0]     r_rsp_b;

  logic [1:0]       w_grant;
  logic             w_id;
  logic             w_accept;
  logic             w_done;
  logic             w_to_hit;
  logic             w_load_job;
  logic             w_load_rsp;
  logic             w_timeout;

  rr_arbiter2 u_arb (
    .valid (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Grant is visible only while idle and out of reset.
  assign req_ready = (r_state == S_IDLE && rst)
                   ? w_grant : 2'b00;
  assign w_accept  = |(req_valid & req_ready);
  assign w_id      = req_ready[1];

  // Only the done of the latched op may end RUN.
  assign w_done = (r_op == OP_DECIPHER)
                ? i_done_decipher : i_done_cipher;

  assign rsp_id  = r_id;
  assign rsp_tag = r_tag;
  assign rsp_a   = r_rsp_a;
  assign rsp_b   = r_rsp_b;
  assign o_a     = r_a;
  assign o_b     = r_b;

`ifdef RC5_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // RUN-cycle counter, restarted for every accepted job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load_job) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Error flag travels with the response it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_load_rsp) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign w_to_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_err  = r_err;
`else
  assign w_to_hit = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, load strobes and state-decoded outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_job       = 1'b0;
    w_load_rsp       = 1'b0;
    w_timeout        = 1'b0;
    o_start_cipher   = 1'b0;
    o_start_decipher = 1'b0;
    rsp_valid        = 1'b0;
    o_key_busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        o_key_busy = 1'b0;
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_load_job  = 1'b1;
        end
      end
      S_RUN: begin
        o_start_cipher   = (r_op == OP_CIPHER);
        o_start_decipher = (r_op == OP_DECIPHER);
        if (w_done) begin
          w_state_nxt = S_RESP;
          w_load_rsp  = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = S_RESP;
          w_timeout   = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Job latch on accept, result capture on done or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= 1'b0;
      r_op    <= OP_CIPHER;
      r_id    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_tag   <= '0;
      r_rsp_a <= '0;
      r_rsp_b <= '0;
    end else begin
      if (w_load_job) begin
        r_ptr <= ~w_id;
        r_id  <= w_id;
        r_op  <= req_dec[w_id];
        r_a   <= w_id ? req_a[2*W-1:W] : req_a[W-1:0];
        r_b   <= w_id ? req_b[2*W-1:W] : req_b[W-1:0];
        r_tag <= w_id ? req_tag[2*TAG_W-1:TAG_W]
                      : req_tag[TAG_W-1:0];
      end
      if (w_load_rsp) begin
        r_rsp_a <= (r_op == OP_DECIPHER)
                 ? i_a_decipher : i_a_cipher;
        r_rsp_b <= (r_op == OP_DECIPHER)
                 ? i_b_decipher : i_b_cipher;
      end
      if (w_timeout) begin
        r_rsp_a <= '0;
        r_rsp_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rc5_job_scheduler.sv
// tb_rc5_job_scheduler: directed + random jobs against an RC5 reference.
// Build with RC5_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_rc5_job_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_dec;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;
  logic        o_start_cipher;
  logic        o_start_decipher;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic        i_done_cipher;
  logic        i_done_decipher;
  logic [31:0] i_a_cipher;
  logic [31:0] i_b_cipher;
  logic [31:0] i_a_decipher;
  logic [31:0] i_b_decipher;
  logic        o_key_busy;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;
  int lat = 2;
  int run_cnt = 0;
  bit mon_en = 0;

  logic        obs_id;
  logic [31:0] obs_a;
  logic [31:0] obs_b;
  logic [63:0] dp_enc;
  logic [63:0] dp_dec;
  logic [31:0] S [0:25];

  rc5_job_scheduler #(
    .W       (32),
    .TAG_W   (4),
    .TIMEOUT (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_dec          (req_dec),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_tag          (req_tag),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_tag          (rsp_tag),
    .rsp_err          (rsp_err),
    .rsp_a            (rsp_a),
    .rsp_b            (rsp_b),
    .o_start_cipher   (o_start_cipher),
    .o_start_decipher (o_start_decipher),
    .o_a              (o_a),
    .o_b              (o_b),
    .i_done_cipher    (i_done_cipher),
    .i_done_decipher  (i_done_decipher),
    .i_a_cipher       (i_a_cipher),
    .i_b_cipher       (i_b_cipher),
    .i_a_decipher     (i_a_decipher),
    .i_b_decipher     (i_b_decipher),
    .o_key_busy       (o_key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rotl(input logic [31:0] x,
                                       input logic [31:0] s);
    logic [4:0] k;
    k = s[4:0];
    if (k == 5'd0) return x;
    return (x << k) | (x >> (6'd32 - {1'b0, k}));
  endfunction

  // RC5-32/12 key expansion for the all-zero 16-byte key.
  task automatic key_setup();
    logic [31:0] L [0:3];
    logic [31:0] A;
    logic [31:0] B;
    int i;
    int j;
    for (int k = 0; k < 4; k++) L[k] = 32'h0;
    S[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) S[k] = S[k-1] + 32'h9E3779B9;
    A = 0; B = 0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      A = rotl(S[i] + A + B, 32'd3);
      S[i] = A;
      B = rotl(L[j] + A + B, A + B);
      L[j] = B;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [63:0] rc5_enc(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    x = a + S[0];
    y = b + S[1];
    for (int r = 1; r <= 12; r++) begin
      x = rotl(x ^ y, y) + S[2*r];
      y = rotl(y ^ x, x) + S[2*r+1];
    end
    return {x, y};
  endfunction

  function automatic logic [63:0] rc5_dec(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    x = a;
    y = b;
    for (int r = 12; r >= 1; r--) begin
      y = rotl(y - S[2*r+1], 32 - {27'd0, x[4:0]}) ^ x;
      x = rotl(x - S[2*r], 32 - {27'd0, y[4:0]}) ^ y;
    end
    return {x - S[0], y - S[1]};
  endfunction

  // Behavioural datapath: done after lat+1 start cycles, noise elsewhere.
  always @(negedge clk) begin
    if (o_start_cipher || o_start_decipher) run_cnt++;
    else run_cnt = 0;
    dp_enc = rc5_enc(o_a, o_b);
    dp_dec = rc5_dec(o_a, o_b);
    i_done_cipher   = o_start_cipher ? (run_cnt > lat) : 1'($urandom);
    i_done_decipher = o_start_decipher ? (run_cnt > lat) : 1'($urandom);
    i_a_cipher   = (o_start_cipher && run_cnt > lat) ? dp_enc[63:32] : $urandom;
    i_b_cipher   = (o_start_cipher && run_cnt > lat) ? dp_enc[31:0] : $urandom;
    i_a_decipher = (o_start_decipher && run_cnt > lat) ? dp_dec[63:32] : $urandom;
    i_b_decipher = (o_start_decipher && run_cnt > lat) ? dp_dec[31:0] : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      assert (req_ready !== 2'b11)
      else begin
        n_err++;
        $error("FAIL ready_onehot: observed=%b expected=not 11", req_ready);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_id, rsp_tag, rsp_err,
                        o_start_cipher, o_start_decipher, o_key_busy}, 0);
    chk({tag, "_op"}, {o_a, o_b}, 0);
    chk({tag, "_rsp"}, {rsp_a, rsp_b}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
  endtask

  // One job from offer to response handshake; called at a negedge in IDLE.
  task automatic job(input logic [1:0] vm, input logic [1:0] dc,
                     input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input logic [3:0] t0, input logic [3:0] t1,
                     input int l, input int stall, input bit hold);
    int win;
    int k;
    logic [31:0] aw;
    logic [31:0] bw;
    logic [3:0]  tw;
    logic        dw;
    logic [63:0] exp;
    logic [1:0]  st;
    win = (vm == 2'b11) ? m_ptr : (vm[1] ? 1 : 0);
    aw  = (win == 1) ? a1 : a0;
    bw  = (win == 1) ? b1 : b0;
    tw  = (win == 1) ? t1 : t0;
    dw  = (win == 1) ? dc[1] : dc[0];
    exp = dw ? rc5_dec(aw, bw) : rc5_enc(aw, bw);
    st  = dw ? 2'b01 : 2'b10;
    lat = l;
    req_dec = dc;
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_tag = {t1, t0};
    rsp_ready = 1'b0;
    req_valid = vm;
    #1;
    chk("grant", req_ready, (win == 1) ? 2'b10 : 2'b01);
    chk("idle_start", {o_start_cipher, o_start_decipher}, 0);
    @(negedge clk);
    if (!hold) req_valid = 2'b00;
    chk("busy", o_key_busy, 1);
    chk("operands", {o_a, o_b}, {aw, bw});
    k = 0;
    while (!rsp_valid && k < 64) begin
      chk("start", {o_start_cipher, o_start_decipher}, st);
      chk("ready_run", req_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("latency", k, l + 1);
    obs_id = rsp_id;
    obs_a = rsp_a;
    obs_b = rsp_b;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, win);
      chk("rsp_tag", rsp_tag, tw);
      chk("rsp_data", {rsp_a, rsp_b}, exp);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_start", {o_start_cipher, o_start_decipher}, 0);
      chk("rsp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready", req_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hs_idle", {rsp_valid, o_key_busy,
                    o_start_cipher, o_start_decipher}, 0);
    m_ptr = (win == 1) ? 0 : 1;
  endtask

  initial begin
    logic [1:0] vm;
    logic [1:0] dc;
    int k;
    rst = 1'b0;
    req_valid = 2'b11;
    req_dec = 2'b00;
    req_a = 64'h0;
    req_b = 64'h0;
    req_tag = 8'h0;
    rsp_ready = 1'b0;
    key_setup();
    do_reset();
    req_valid = 2'b00;
    mon_en = 1'b1;
    @(negedge clk);

    // Known-answer cipher from requester 0.
    job(2'b01, 2'b00, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222,
        4'd3, 4'd9, 4, 0, 1'b0);
    chk("kat_id", obs_id, 0);
    chk("kat_a", obs_a, 32'hEEDBA521);
    chk("kat_b", obs_b, 32'h6D8F4B15);

    // Decipher it back from requester 1.
    job(2'b10, 2'b10, 32'h5555_5555, 32'h6666_6666,
        32'hEEDBA521, 32'h6D8F4B15, 4'd1, 4'd5, 2, 0, 1'b0);
    chk("inv_id", obs_id, 1);
    chk("inv_data", {obs_a, obs_b}, 0);

    // Both requesters valid continuously from reset.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      job(2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
          4'($urandom), 4'($urandom), $urandom_range(0, 5), 0, 1'b1);
      chk("rr_seq", obs_id, n % 2);
    end
    req_valid = 2'b00;

    // Long response back-pressure with a new request pending.
    job(2'b01, 2'b01, $urandom, $urandom, $urandom, $urandom,
        4'hC, 4'h2, 3, 10, 1'b1);
    req_valid = 2'b00;

    // Random traffic.
    for (int n = 0; n < 16; n++) begin
      vm = 2'($urandom_range(1, 3));
      dc = 2'($urandom);
      job(vm, dc, $urandom, $urandom, $urandom, $urandom,
          4'($urandom), 4'($urandom), $urandom_range(0, 8),
          $urandom_range(0, 3), 1'b0);
    end

    // Reset in the fifth RUN cycle aborts the job.
    lat = 20;
    req_dec = 2'b00;
    req_a = {32'h0, 32'h0BAD_F00D};
    req_b = {32'h0, 32'h1234_5678};
    req_tag = 8'h07;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("abort_run", o_start_cipher, 1);
    rst = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    chk("abort_norsp", rsp_valid, 0);
    rst = 1'b1;
    m_ptr = 0;
    job(2'b11, 2'b00, $urandom, $urandom, $urandom, $urandom,
        4'hA, 4'h5, 3, 1, 1'b0);
    chk("post_abort_id", obs_id, 0);

`ifdef RC5_SCHED_TIMEOUT_EN
    // Datapath never finishes: watchdog ends the job after 16 RUN cycles.
    lat = 100000;
    req_dec = 2'b00;
    req_a = {32'hCAFE_0001, 32'h0};
    req_b = {32'hCAFE_0002, 32'h0};
    req_tag = 8'hB0;
    req_valid = 2'b10;
    #1;
    chk("to_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    k = 0;
    while (o_start_cipher && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("to_run_cycles", k, 16);
    chk("to_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_data", {rsp_a, rsp_b}, 0);
    chk("to_id", rsp_id, 1);
    chk("to_tag", rsp_tag, 4'hB);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_idle", o_key_busy, 0);
`else
    k = 0;
`endif

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
